// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg
//   Shared definitions for the FIFO write-port arbiter:
//   - arb_state_e : arbiter state (IDLE / BURST)
//   - *_DEF       : default parameter values used by fifo_wr_arbiter
package fifo_wr_arb_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set bit of req at or
//   after index ptr, searching upward and wrapping modulo NREQ.
//   Ports:
//     req   [NREQ-1:0] in   request vector
//     ptr   [PW-1:0]   in   search start index
//     pick  [NREQ-1:0] out  one-hot selected requester (zero when none)
//     valid            out  at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    int idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter in front of a FIFO write port. A grant is held for a
//   burst of up to MAX_BURST accepted beats; the burst also ends early when the
//   granted requester drops its request. On burst end the pointer advances past
//   the granted index and a new grant is issued on the same edge, so
//   back-to-back bursts have no idle cycle.
//   Ports:
//     wr_clk, wr_rst       clock, asynchronous active-high reset
//     req      [NREQ]      per-requester request (held with data until acked)
//     req_data [NREQ*DW]   requester i data at [i*DW +: DW]
//     fifo_full            FIFO full, stalls the current beat
//     gnt      [NREQ]      registered one-hot grant, zero when idle
//     req_ack  [NREQ]      beat accepted for the granted requester
//     wr_en, wr_data [DW]  FIFO write strobe and data
//     busy                 arbiter is in a burst
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 fifo_full,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      req_ack,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic                 busy
);

    localparam int            PW        = $clog2(NREQ);
    localparam int            CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   g_idx;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            req_g;
    logic            beat;
    logic            burst_end;

    assign busy    = (state_q == BURST);
    assign gnt     = gnt_q;

    // Binary index of the granted requester plus its data slice. Only the
    // granted slice reaches wr_data, so other requesters cannot disturb it.
    always_comb begin
        g_idx   = '0;
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                g_idx = PW'(i);
                if (busy) wr_data = req_data[i*DW +: DW];
            end
        end
    end

    assign req_g     = |(req & gnt_q);
    assign beat      = busy && req_g && !fifo_full;
    assign wr_en     = beat;
    assign req_ack   = beat ? gnt_q : '0;
    assign ptr_nxt   = (g_idx == LAST_IDX) ? '0 : g_idx + 1'b1;
    // A stalled beat never ends a burst by count; only a dropped request can.
    assign burst_end = busy && ((beat && cnt_q == LAST_BEAT) || !req_g);
    // While busy the picker looks ahead from the post-burst pointer so the
    // re-grant lands on the same edge as the burst end.
    assign pick_ptr  = busy ? ptr_nxt : ptr_q;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BURST;
                    gnt_d   = pick;
                end
            end
            BURST: begin
                if (burst_end) begin
                    ptr_d = ptr_nxt;
                    cnt_d = '0;
                    if (pick_vld) begin
                        gnt_d = pick;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, MAX_BURST=4). Each
//   requester streams words i*64+k from a small per-requester store; the
//   expected accept order is queued up front and a negedge monitor pops and
//   compares on every wr_en beat.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 16;

    logic                 wr_clk = 1'b0;
    logic                 wr_rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic                 fifo_full;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      req_ack;
    logic                 wr_en;
    logic [DW-1:0]        wr_data;
    logic                 busy;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .req       (req),
        .req_data  (req_data),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .req_ack   (req_ack),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } beat_t;

    beat_t           exp_q[$];
    logic [DW-1:0]   src_mem [NREQ][DEPTH];
    int              rd_ptr  [NREQ];
    int              wr_ptr  [NREQ];
    logic [NREQ-1:0] ack_lat;
    logic            rnd_en;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (rd_ptr[i] != wr_ptr[i]);
            req_data[i*DW +: DW] = req[i] ? src_mem[i][rd_ptr[i]] : '0;
        end
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[i][wr_ptr[i]] = DW'(i * 64 + wr_ptr[i]);
            wr_ptr[i]++;
        end
        refresh();
    endtask

    task automatic push_exp(input int idx, input int k);
        beat_t e;
        e.idx  = idx;
        e.data = DW'(idx * 64 + k);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        wr_rst    = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rd_ptr[i] = 0;
            wr_ptr[i] = 0;
        end
        exp_q.delete();
        refresh();
        repeat (2) @(posedge wr_clk);
    endtask

    task automatic release_reset();
        @(posedge wr_clk);
        #2 wr_rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge wr_clk);
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 0);
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    // Requester model: an accepted word is retired on the edge that took it.
    always @(negedge wr_clk) ack_lat = req_ack;

    always @(posedge wr_clk) begin
        #1;
        if (!wr_rst) begin
            for (int i = 0; i < NREQ; i++)
                if (ack_lat[i] && rd_ptr[i] != wr_ptr[i]) rd_ptr[i]++;
        end
        refresh();
    end

    always @(posedge wr_clk) begin
        #1;
        if (rnd_en) fifo_full = 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor.
    always @(negedge wr_clk) begin : mon
        beat_t e;
        if (!wr_rst && wr_en) begin
            chk("beat_while_full", 32'(fifo_full), 0);
            chk("ack_eq_gnt", 32'(req_ack), 32'(gnt));
            chk("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_data", 32'(wr_data), 32'(e.data));
                chk("req_ack", 32'(req_ack), 32'(1 << e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        wr_rst    = 1'b0;
        rnd_en    = 1'b0;
        ack_lat   = '0;
        #1;

        // Reset state, then single requester streaming across bursts.
        apply_reset();
        load(0, 10);
        for (int k = 0; k < 10; k++) push_exp(0, k);
        @(negedge wr_clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        release_reset();
        @(posedge wr_clk);
        repeat (10) begin
            @(negedge wr_clk);
            chk("single_wr_en", 32'(wr_en), 1);
            chk("single_gnt", 32'(gnt), 1);
        end
        wait_drain("single", 20);

        // All four requesting: 0,1,2,3,0 with four beats each, no gaps.
        apply_reset();
        load(0, 8); load(1, 4); load(2, 4); load(3, 4);
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 4; k++) push_exp(b % 4, (b / 4) * 4 + k);
        release_reset();
        @(posedge wr_clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge wr_clk);
            chk("rr_wr_en", 32'(wr_en), 1);
            chk("rr_gnt", 32'(gnt), 32'(1 << ((c / 4) % 4)));
        end
        wait_drain("rr", 20);

        // Grant to 2, FIFO full for three cycles after beat 2.
        apply_reset();
        load(2, 4); load(3, 2);
        for (int k = 0; k < 4; k++) push_exp(2, k);
        push_exp(3, 0); push_exp(3, 1);
        release_reset();
        @(posedge wr_clk);
        @(negedge wr_clk); chk("full_b1", 32'(wr_en), 1);
        @(negedge wr_clk); chk("full_b2", 32'(wr_en), 1);
        @(posedge wr_clk);
        #1 fifo_full = 1'b1;
        repeat (3) begin
            @(negedge wr_clk);
            chk("full_stall_wr_en", 32'(wr_en), 0);
            chk("full_stall_gnt", 32'(gnt), 4);
        end
        @(posedge wr_clk);
        #1 fifo_full = 1'b0;
        @(negedge wr_clk); chk("full_b3", 32'(wr_en), 1);
        @(negedge wr_clk); chk("full_b4", 32'(wr_en), 1);
        chk("full_b4_gnt", 32'(gnt), 4);
        @(negedge wr_clk); chk("full_next_gnt", 32'(gnt), 8);
        wait_drain("full", 20);

        // Grant to 1, req[1] drops after one beat; pointer moves to 2.
        apply_reset();
        load(1, 1); load(3, 2);
        push_exp(1, 0); push_exp(3, 0); push_exp(3, 1); push_exp(0, 0);
        release_reset();
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("drop_gnt1", 32'(gnt), 2);
        chk("drop_beat", 32'(wr_en), 1);
        @(posedge wr_clk);
        #1 load(0, 1);
        @(negedge wr_clk);
        chk("drop_no_beat", 32'(wr_en), 0);
        chk("drop_gnt_hold", 32'(gnt), 2);
        @(negedge wr_clk);
        chk("drop_ptr2_gnt3", 32'(gnt), 8);
        repeat (3) @(negedge wr_clk);
        chk("drop_wrap_gnt0", 32'(gnt), 1);
        wait_drain("drop", 20);
        chk("drop_idle_gnt", 32'(gnt), 0);

        // Asynchronous reset in the middle of a beat.
        apply_reset();
        load(0, 6);
        push_exp(0, 0);
        release_reset();
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("arst_pre_beat", 32'(wr_en), 1);
        #2 wr_rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_wr_data", 32'(wr_data), 0);
        apply_reset();
        load(3, 1);
        push_exp(3, 0);
        release_reset();
        @(posedge wr_clk);
        @(negedge wr_clk);
        chk("arst_first_gnt", 32'(gnt), 8);
        chk("arst_first_data", 32'(wr_data), 32'hC0);
        wait_drain("arst", 20);

        // Random FIFO-full stalls: accept order must be unchanged.
        apply_reset();
        for (int i = 0; i < NREQ; i++) load(i, 8);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < 4; k++) push_exp(b % 4, (b / 4) * 4 + k);
        rnd_en = 1'b1;
        release_reset();
        wait_drain("rnd", 400);
        rnd_en = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++)
            chk("rnd_src_empty", 32'(wr_ptr[i] - rd_ptr[i]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of write requesters (2..8).
REQ-002 Parameter DW, 8, FIFO write data width.
REQ-003 Parameter MAX_BURST, 4, max accepted beats per grant (1..15).
REQ-004 wr_clk  input  1  write-domain clock; all state updates on rising edge.
REQ-005 wr_rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester write request; bit i held with its data until accepted.
REQ-007 req_data  input  NREQ*DW  flattened data; requester i occupies bits [i*DW +: DW].
REQ-008 fifo_full  input  1  full flag from the FIFO write-pointer block.
REQ-009 gnt  output  NREQ  one-hot registered grant; all-zero when idle.
REQ-010 req_ack  output  NREQ  bit i high in the cycle requester i's beat is accepted.
REQ-011 wr_en  output  1  FIFO write enable.
REQ-012 wr_data  output  DW  FIFO write data.
REQ-013 busy  output  1  high while in state BURST.

Function
REQ-014 Two states: IDLE, BURST; state, gnt, priority pointer and beat counter are registers.
REQ-015 IDLE: if req != 0, the next edge enters BURST with gnt set to the first requesting index at or after the pointer, searching upward modulo NREQ; otherwise stay IDLE.
REQ-016 Beat: wr_en = busy && req[g] && !fifo_full, where g is the granted index; combinational from registers and inputs.
REQ-017 wr_data = req_data slice g while busy; all-zero otherwise.
REQ-018 req_ack = gnt when wr_en is high; zero otherwise.
REQ-019 Each beat increments the beat counter, which is ceil(log2(MAX_BURST+1)) bits wide and never exceeds MAX_BURST.
REQ-020 fifo_full high: no beat, counter holds, grant holds.
REQ-021 Burst end, evaluated each edge in BURST: a beat brings the count to MAX_BURST, or req[g] is low.
REQ-022 At burst end: pointer <= (g+1) mod NREQ, counter <= 0, and the same edge re-arbitrates from the new pointer (excluding g only when req[g] is low). With any eligible request, stay in BURST with the new gnt; otherwise go to IDLE with gnt = 0.
REQ-023 Round-robin fairness: a continuously requesting requester waits at most (NREQ-1) bursts.
REQ-024 A requester that raises req mid-burst is not granted until the current burst ends.
REQ-025 The single-requester case is supported: at burst end the same requester is re-granted with a zero-cycle gap.
REQ-026 Changes to req bits other than g during BURST do not affect wr_en or wr_data.

Reset
REQ-027 Asserting wr_rst forces immediately: state IDLE, gnt 0, pointer 0, counter 0, hence wr_en 0, req_ack 0, busy 0, wr_data 0.
REQ-028 Reset mid-burst discards the burst; no partial state survives.
REQ-029 On the first edge after deassertion, normal arbitration from pointer 0 applies.

Structure
REQ-030 Package fifo_wr_arb_pkg holds the state enumeration (IDLE, BURST) and the default parameter constants.
REQ-031 A combinational sub-module rr_pick holds the round-robin picker (inputs: request vector, pointer; outputs: one-hot pick, valid); it is instantiated once.
REQ-032 Target size is 120-400 lines of RTL; no memories and no second clock domain.

Verification
REQ-033 NREQ=4, MAX_BURST=4; req=4'b0001 held, fifo_full=0 -> wr_en high every cycle from the 2nd edge; gnt stays 4'b0001 across bursts.
REQ-034 req=4'b1111 held -> grants in order 0,1,2,3,0, each for exactly 4 wr_en beats, with no idle cycle between bursts.
REQ-035 Grant to 2; fifo_full=1 for 3 cycles after beat 2 -> wr_en low for those 3 cycles; beats 3-4 then complete; the grant moves to 3.
REQ-036 Grant to 1; req[1] drops after beat 1 -> the burst ends at that edge; the pointer becomes 2; gnt goes to the next requester, or to 0 (IDLE) if none.
REQ-037 wr_rst asserted mid-beat (asynchronously) -> gnt, wr_en and busy are 0 in the same cycle; after release with req=4'b1000, the first grant is 4'b1000 from pointer 0.
REQ-038 Scoreboard: the wr_data sequence equals the per-requester data in accept order; no beat is lost or duplicated while fifo_full toggles randomly.
